// File: rtl/if_prefetch_stage_if.sv
// ----------------------------------------------------------------------------
// if_prefetch_stage_if
//  Fetch-side memory port of the instruction-fetch stage. One request channel
//  (req/addr, accepted by gnt) and one response channel (rvalid/rdata).
//  Parameters:
//   ADD_WIDTH  word address width
//   DAT_WIDTH  read data width
//  Signals:
//   mem_req     fetch request, held until mem_gnt
//   mem_addr    fetch word address, meaningful on mem_req & mem_gnt
//   mem_gnt     address accepted this cycle
//   mem_rvalid  read data valid (at least one cycle after the grant)
//   mem_rdata   read data
//  Modports:
//   master  the fetch stage (drives req/addr)
//   slave   the memory / bus bridge (drives gnt/rvalid/rdata)
// ----------------------------------------------------------------------------
interface if_prefetch_stage_if #(
    parameter int ADD_WIDTH = 30,
    parameter int DAT_WIDTH = 32
);
    logic                 mem_req;
    logic [ADD_WIDTH-1:0] mem_addr;
    logic                 mem_gnt;
    logic                 mem_rvalid;
    logic [DAT_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/if_prefetch_stage.sv
// ----------------------------------------------------------------------------
// if_prefetch_stage
//  Instruction-fetch stage with a DEPTH-entry prefetch queue. Fetches ahead of
//  decode through a single memory port with at most one outstanding access,
//  tolerates wait states, and redirects on flush (highest priority) or taken
//  branch. A fetch that is in flight when a redirect happens is discarded when
//  its data returns.
//  Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   mem                  memory port (master side of if_prefetch_stage_if)
//   flush_i, new_pc_i    redirect to new_pc_i (wins over branch)
//   br_taken_i, br_addr_i redirect to br_addr_i
//   if_ready_i           decode accepts the queue head
//   if_valid_o           queue head valid
//   if_pc_o, if_instru_o PC and instruction at the queue head
//   pip_busy_o           queue empty while a fetch is pending
// ----------------------------------------------------------------------------
module if_prefetch_stage #(
    parameter int                   DAT_WIDTH = 32,
    parameter int                   ADD_WIDTH = 30,
    parameter int                   DEPTH     = 4,
    parameter logic [ADD_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    if_prefetch_stage_if.master  mem,
    input  logic                 flush_i,
    input  logic [ADD_WIDTH-1:0] new_pc_i,
    input  logic                 br_taken_i,
    input  logic [ADD_WIDTH-1:0] br_addr_i,
    input  logic                 if_ready_i,
    output logic                 if_valid_o,
    output logic [ADD_WIDTH-1:0] if_pc_o,
    output logic [DAT_WIDTH-1:0] if_instru_o,
    output logic                 pip_busy_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t               state_q, state_d;
    logic [ADD_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ADD_WIDTH-1:0] q_pc_q    [DEPTH];
    logic [DAT_WIDTH-1:0] q_instr_q [DEPTH];

    logic                 redirect;
    logic [ADD_WIDTH-1:0] redirect_pc;
    logic                 pop;
    logic                 push;
    logic                 req;
    logic [CNT_W-1:0]     count_after_pop;
    logic [DEPTH-1:0]     wr_en;

    assign redirect    = flush_i | br_taken_i;
    assign redirect_pc = flush_i ? new_pc_i : br_addr_i;

    // A redirect empties the queue this cycle, so the head is not consumed.
    assign pop             = if_valid_o & if_ready_i & ~redirect;
    assign count_after_pop = count_q - CNT_W'(pop);

    // ------------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req        = 1'b0;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = S_REQ;
                end else if (count_q < CNT_W'(DEPTH)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                req = 1'b1;
                if (redirect) begin
                    // A grant in this cycle accepted the old address: its data is stale.
                    fetch_pc_d = redirect_pc;
                    state_d    = mem.mem_gnt ? S_DROP : S_REQ;
                end else if (mem.mem_gnt) begin
                    fetch_pc_d = fetch_pc_q + ADD_WIDTH'(1);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = mem.mem_rvalid ? S_REQ : S_DROP;
                end else if (mem.mem_rvalid) begin
                    push = 1'b1;
                    // The outstanding access retires this cycle, so the next request
                    // may go out right away; this keeps one fetch per cycle with a
                    // zero-wait slave. It needs room for the entry just pushed plus
                    // the new in-flight one.
                    if (count_after_pop < CNT_W'(DEPTH - 1)) begin
                        req = 1'b1;
                        if (mem.mem_gnt) begin
                            fetch_pc_d = fetch_pc_q + ADD_WIDTH'(1);
                            state_d    = S_WAIT;
                        end else begin
                            state_d = S_REQ;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
                if (mem.mem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Queue pointers
    // ------------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Queue storage: one write enable per entry
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = push && (wr_ptr_q == PTR_W'(gi));
    end

    // Entries are reset so the head reads as zero out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    q_pc_q[i]    <= fetch_pc_q - ADD_WIDTH'(1);
                    q_instr_q[i] <= mem.mem_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mem.mem_req  = req;
    assign mem.mem_addr = fetch_pc_q;
    assign if_valid_o   = (count_q != '0);
    assign if_pc_o      = q_pc_q[rd_ptr_q];
    assign if_instru_o  = q_instr_q[rd_ptr_q];
    assign pip_busy_o   = (count_q == '0) && (state_q != S_IDLE);

endmodule

// File: tb/tb_if_prefetch_stage.sv
module tb_if_prefetch_stage;
    localparam int AW    = 30;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          br    = 1'b0;
    logic          ready = 1'b0;
    logic [AW-1:0] new_pc  = '0;
    logic [AW-1:0] br_addr = '0;
    logic          if_valid;
    logic [AW-1:0] if_pc;
    logic [DW-1:0] if_instr;
    logic          pip_busy;

    always #5 clk = ~clk;

    if_prefetch_stage_if #(.ADD_WIDTH(AW), .DAT_WIDTH(DW)) bus ();

    if_prefetch_stage #(
        .DAT_WIDTH(DW),
        .ADD_WIDTH(AW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .mem        (bus),
        .flush_i    (flush),
        .new_pc_i   (new_pc),
        .br_taken_i (br),
        .br_addr_i  (br_addr),
        .if_ready_i (ready),
        .if_valid_o (if_valid),
        .if_pc_o    (if_pc),
        .if_instru_o(if_instr),
        .pip_busy_o (pip_busy)
    );

    function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
        return {a, 2'b01} ^ 32'hDEAD_BEEF;
    endfunction

    // Memory slave: one pending access, rvalid lat cycles after the grant.
    // It is deliberately not reset with the DUT so a stale response can arrive
    // after the DUT comes out of reset.
    int            lat    = 1;
    logic          gnt_en = 1'b1;
    logic          pend_v = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    int            pend_cnt  = 0;

    assign bus.mem_gnt    = bus.mem_req & gnt_en;
    assign bus.mem_rvalid = pend_v && (pend_cnt == 0);
    assign bus.mem_rdata  = bus.mem_rvalid ? instr_of(pend_addr) : '0;

    always @(posedge clk) begin
        if (bus.mem_rvalid) pend_v <= 1'b0;
        else if (pend_v && pend_cnt > 0) pend_cnt <= pend_cnt - 1;
        if (bus.mem_req && bus.mem_gnt) begin
            pend_v    <= 1'b1;
            pend_addr <= bus.mem_addr;
            pend_cnt  <= lat - 1;
        end
    end

    // Checking and scoreboard
    int            checks   = 0;
    int            failures = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr = '0;
    int            hs_cnt   = 0;
    int            gnt_cnt  = 0;
    logic          rand_ready = 1'b0;
    logic          rand_gnt   = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected instruction stream after a (re)start at pc: sequential PCs with
    // address wrap, and the next granted fetch address.
    task automatic sb_restart(input logic [AW-1:0] pc);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(pc + AW'(i));
        exp_addr = pc;
    endtask

    task automatic monitor();
        logic [AW-1:0] e;
        if (rst_n) begin
            if (bus.mem_req && bus.mem_gnt) begin
                check_eq("one_outstanding", {63'd0, pend_v && !bus.mem_rvalid}, 64'd0);
                check_eq("fetch_addr", {34'd0, bus.mem_addr}, {34'd0, exp_addr});
                exp_addr = exp_addr + AW'(1);
                gnt_cnt++;
            end
            if (flush || br) begin
                sb_restart(flush ? new_pc : br_addr);
            end else if (if_valid && ready) begin
                check_eq("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("if_pc", {34'd0, if_pc}, {34'd0, e});
                    check_eq("if_instr", {32'd0, if_instr}, {32'd0, instr_of(e)});
                end
                hs_cnt++;
                $display("HS t=%0t pc=0x%08h instr=0x%08h", $time, if_pc, if_instr);
            end
        end
    endtask

    // Called at a negedge with inputs set; each iteration checks the cycle
    // ending at the next posedge and returns at the following negedge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (rand_ready) ready  = 1'($urandom_range(0, 1));
            if (rand_gnt)   gnt_en = 1'($urandom_range(0, 1));
            #1;
            monitor();
            @(negedge clk);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_valid"}, {63'd0, if_valid}, 64'd0);
        check_eq({tag, "_pc"},    {34'd0, if_pc}, 64'd0);
        check_eq({tag, "_instr"}, {32'd0, if_instr}, 64'd0);
        check_eq({tag, "_req"},   {63'd0, bus.mem_req}, 64'd0);
        check_eq({tag, "_addr"},  {34'd0, bus.mem_addr}, 64'd0);
        check_eq({tag, "_busy"},  {63'd0, pip_busy}, 64'd0);
    endtask

    task automatic wait_pending(input string tag, input int min_cnt);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (pend_v && !bus.mem_rvalid && pend_cnt >= min_cnt) begin
                found = 1'b1;
                break;
            end
            run(1);
        end
        check_eq(tag, {63'd0, found}, 64'd1);
    endtask

    initial begin
        int vcnt;
        sb_restart('0);
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("rst0");

        // 1: zero-wait slave, ready from reset, full throughput
        ready = 1'b1;
        rst_n = 1'b1;
        run(1);
        #1;
        check_eq("busy_fill", {63'd0, pip_busy}, 64'd1);
        run(8);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            vcnt += int'(if_valid);
            run(1);
        end
        check_eq("throughput", 64'(vcnt), 64'd20);

        // 2: decode stalled from reset -> exactly DEPTH grants, then resume
        rst_n = 1'b0;
        ready = 1'b0;
        run(2);
        sb_restart('0);
        gnt_cnt = 0;
        rst_n = 1'b1;
        run(20);
        check_eq("stall_grants", 64'(gnt_cnt), 64'(DEPTH));
        check_eq("stall_req_low", {63'd0, bus.mem_req}, 64'd0);
        check_eq("stall_not_busy", {63'd0, pip_busy}, 64'd0);
        ready  = 1'b1;
        hs_cnt = 0;
        run(12);
        check_eq("stall_resume", {63'd0, hs_cnt >= DEPTH}, 64'd1);

        // 3: wait-state slave, flush while a fetch is outstanding
        lat = 3;
        run(10);
        wait_pending("wait_seen", 0);
        flush  = 1'b1;
        new_pc = AW'(32'h100);
        run(1);
        flush = 1'b0;
        check_eq("flush_clear", {63'd0, if_valid}, 64'd0);
        hs_cnt = 0;
        run(40);
        check_eq("flush_resume", {63'd0, hs_cnt > 0}, 64'd1);

        // 4: flush and branch together, random stalls and grant delays
        lat        = 2;
        rand_ready = 1'b1;
        rand_gnt   = 1'b1;
        run(15);
        flush   = 1'b1;
        new_pc  = AW'(32'h200);
        br      = 1'b1;
        br_addr = AW'(32'h300);
        run(1);
        flush = 1'b0;
        br    = 1'b0;
        check_eq("both_clear", {63'd0, if_valid}, 64'd0);
        hs_cnt = 0;
        run(60);
        check_eq("both_resume", {63'd0, hs_cnt > 0}, 64'd1);

        // 5: branch to the last word, PC wraps to zero
        lat      = 1;
        rand_gnt = 1'b0;
        gnt_en   = 1'b1;
        run(5);
        br      = 1'b1;
        br_addr = '1;
        run(1);
        br     = 1'b0;
        hs_cnt = 0;
        run(30);
        check_eq("wrap_count", {63'd0, hs_cnt >= 2}, 64'd1);

        // 6: reset during an outstanding fetch, stale rvalid after release
        rand_ready = 1'b0;
        ready      = 1'b1;
        lat        = 6;
        run(8);
        wait_pending("rst_wait_seen", 4);
        gnt_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        #1;
        check_reset_values("rst_mid");
        rst_n = 1'b1;
        sb_restart('0);
        for (int i = 0; i < 12; i++) begin
            if (!pend_v) break;
            run(1);
        end
        check_eq("stale_retired", {63'd0, pend_v}, 64'd0);
        check_eq("stale_no_valid", {63'd0, if_valid}, 64'd0);
        gnt_en = 1'b1;
        lat    = 1;
        hs_cnt = 0;
        run(20);
        check_eq("rst_resume", {63'd0, hs_cnt > 0}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
